// File: rtl/hamming_coder_12_8.sv
// Hamming(12,8) SEC encoder and independent single-error-correcting decoder.
// Each half is one register stage with purely combinational logic in front.
module hamming_coder_12_8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  data,
  output logic [11:0] hc_out,
  input  logic [11:0] hc_in,
  output logic [7:0]  q
);

  logic [11:0] hc_d, hc_q;
  logic [7:0]  q_d, q_q;
  logic [3:0]  syndrome;
  logic [11:0] flip_mask;
  logic [11:0] fixed;

  // Encoder: codeword position p lives at bit p-1; parity at positions 1, 2, 4, 8.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    hc_d        = '0;
    hc_d[0]     = data[0] ^ data[1] ^ data[3] ^ data[4] ^ data[6];
    hc_d[1]     = data[0] ^ data[2] ^ data[3] ^ data[5] ^ data[6];
    hc_d[2]     = data[0];
    hc_d[3]     = data[1] ^ data[2] ^ data[3] ^ data[7];
    hc_d[6:4]   = data[3:1];
    hc_d[7]     = data[4] ^ data[5] ^ data[6] ^ data[7];
    hc_d[11:8]  = data[7:4];
  end

  // Syndrome bit k covers every received position whose index has bit k set.
  always_comb begin
    syndrome    = '0;
    syndrome[0] = hc_in[0] ^ hc_in[2] ^ hc_in[4] ^ hc_in[6] ^ hc_in[8] ^ hc_in[10];
    syndrome[1] = hc_in[1] ^ hc_in[2] ^ hc_in[5] ^ hc_in[6] ^ hc_in[9] ^ hc_in[10];
    syndrome[2] = hc_in[3] ^ hc_in[4] ^ hc_in[5] ^ hc_in[6] ^ hc_in[11];
    syndrome[3] = hc_in[7] ^ hc_in[8] ^ hc_in[9] ^ hc_in[10] ^ hc_in[11];
  end

  // Syndromes 13..15 point past the codeword: leave the word untouched.
  always_comb begin
    flip_mask = '0;
    if (syndrome != 4'd0 && syndrome <= 4'd12) begin
      flip_mask = 12'h001 << (syndrome - 4'd1);
    end
    fixed = hc_in ^ flip_mask;
    q_d   = {fixed[11:8], fixed[6:4], fixed[2]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q <= '0;
      q_q  <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
      hc_q <= hc_d;
      q_q  <= q_d;
    end
  end

  assign hc_out = hc_q;
  assign q      = q_q;

endmodule

// File: tb/tb_hamming_coder_12_8.sv
// Self-checking bench for hamming_coder_12_8: behavioural Hamming model,
// literal spot checks, and a randomized loopback channel with single-bit flips.
module tb_hamming_coder_12_8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data = 8'hA5;
  logic [11:0] hc_in = 12'h000;
  logic [11:0] hc_out;
  logic [7:0]  q;

  int total = 0;
  int bad   = 0;

  logic        cmp_en  = 1'b0;
  logic        chan_on = 1'b0;
  logic        flip_on = 1'b0;
  int          e2e_cnt = 0;
  logic [11:0] exp_hc;
  logic [7:0]  exp_q;
  logic [7:0]  d1, d2;

  hamming_coder_12_8 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .hc_out (hc_out),
    .hc_in  (hc_in),
    .q      (q)
  );

  always #5 clk = ~clk;

  // Generic Hamming construction: data fills the non-power-of-two positions in
  // order, then each parity position 2^k makes its covered group even.
  function automatic logic [11:0] model_enc(input logic [7:0] d);
    logic [11:0] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    for (int b = 1; b <= 8; b = b * 2) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++) if ((p & b) != 0) par ^= cw[p-1];
      cw[b-1] = par;
    end
    return cw;
  endfunction

  // Syndrome is the XOR of the indices of all set positions.
  function automatic logic [7:0] model_dec(input logic [11:0] h);
    logic [11:0] w;
    logic [7:0]  d;
    int          s;
    int          k;
    w = h;
    s = 0;
    for (int p = 1; p <= 12; p++) if (w[p-1]) s ^= p;
    if (s >= 1 && s <= 12) w[s-1] = ~w[s-1];
    d = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = w[p-1];
        k++;
      end
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive both inputs away from the edge, then check after the capturing edge.
  task automatic step_chk(input string name, input logic [7:0] d, input logic [11:0] h,
                          input logic [11:0] want_hc, input logic [7:0] want_q);
    @(negedge clk);
    data  = d;
    hc_in = h;
    @(negedge clk);
    check({name, "_hc_out"}, 32'(hc_out), 32'(want_hc));
    check({name, "_q"}, 32'(q), 32'(want_q));
  endtask

  // Reference registers: what the outputs must hold after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_hc <= '0;
      exp_q  <= '0;
    end else begin
      exp_hc <= model_enc(data);
      exp_q  <= model_dec(hc_in);
    end
  end

  always @(posedge clk) begin
    d2 <= d1;
    d1 <= data;
  end

  // External channel: copy hc_out shortly after the edge, optionally with one flipped bit.
  always @(posedge clk) begin
    logic [11:0] mask;
    if (!chan_on) begin
      e2e_cnt = 0;
    end else begin
      e2e_cnt++;
      mask = 12'h000;
      if (flip_on) mask = 12'h001 << $urandom_range(11, 0);
      #1 hc_in = hc_out ^ mask;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_hc_out", 32'(hc_out), 32'(exp_hc));
      check("model_q", 32'(q), 32'(exp_q));
      if (chan_on && rst_n && e2e_cnt >= 3) check("loop_q", 32'(q), 32'(d2));
    end
  end

  initial begin
    logic [11:0] one;
    one = 12'h001;

    // Pin the model against hand-computed codewords.
    check("model_enc_00", 32'(model_enc(8'h00)), 32'h000);
    check("model_enc_01", 32'(model_enc(8'h01)), 32'h007);
    check("model_enc_ff", 32'(model_enc(8'hFF)), 32'hF77);
    check("model_dec_s13", 32'(model_dec(12'h801)), 32'h80);

    // Reset held with live input.
    repeat (3) @(negedge clk);
    check("rst_hc_out", 32'(hc_out), 32'h000);
    check("rst_q", 32'(q), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_hc_out", 32'(hc_out), 32'hA27);
    check("post_rst_q", 32'(q), 32'h00);
    cmp_en = 1'b1;

    step_chk("enc_00", 8'h00, 12'h000, 12'h000, 8'h00);
    step_chk("enc_01", 8'h01, 12'h007, 12'h007, 8'h01);
    step_chk("enc_ff", 8'hFF, 12'hF77, 12'hF77, 8'hFF);

    for (int i = 0; i < 12; i++) begin
      step_chk($sformatf("sweep_ff_b%0d", i), 8'hFF, 12'hF77 ^ (one << i), 12'hF77, 8'hFF);
    end
    for (int i = 0; i < 12; i++) begin
      step_chk($sformatf("sweep_01_b%0d", i), 8'h01, 12'h007 ^ (one << i), 12'h007, 8'h01);
    end

    // Syndromes 13, 14, 15 (positions {1,12}, {2,12}, {3,12}): raw data positions pass through.
    step_chk("uncorr_s13", 8'h00, 12'h801, 12'h000, 8'h80);
    step_chk("uncorr_s14", 8'h00, 12'h802, 12'h000, 8'h80);
    step_chk("uncorr_s15", 8'h00, 12'h804, 12'h000, 8'h81);

    // Clean loopback, then a channel that flips one random bit per cycle.
    chan_on = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      data = 8'($urandom);
    end
    flip_on = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      data = 8'($urandom);
    end

    // Mid-stream asynchronous reset clears both registers without an edge.
    @(negedge clk);
    data = 8'hFF;
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    chan_on = 1'b0;
    #1;
    check("mid_rst_hc_out", 32'(hc_out), 32'h000);
    check("mid_rst_q", 32'(q), 32'h00);
    @(negedge clk);
    rst_n   = 1'b1;
    chan_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      data = 8'($urandom);
    end

    chan_on = 1'b0;
    flip_on = 1'b0;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
